// File: rtl/sd_solver_param_if.sv
// Cell-stream bus between the serial grid loader, the Sudoku solver and the result sink.
// in_valid qualifies in for N*N consecutive cycles, out_valid qualifies out; there is no backpressure.
interface sd_solver_param_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic [W-1:0] in;
  logic         out_valid;
  logic [W-1:0] out;

  modport master (output in_valid, output in, input out_valid, input out);
  modport slave  (input in_valid, input in, output out_valid, output out);
endinterface

// File: rtl/sd_solver_param.sv
// Parametrised backtracking Sudoku solver: loads a BOX*BOX grid, checks the givens, solves the blanks.
// Defining SD_TIMEOUT_EN adds a saturating solve-cycle budget that aborts with FAIL after TIMEOUT cycles.
module sd_solver_param #(
  parameter int BOX       = 3,
  parameter int MAX_EMPTY = 16,
  parameter int TIMEOUT   = 4096
) (
  input logic              clk,
  input logic              rst_n,
  sd_solver_param_if.slave bus
);
  localparam int N  = BOX * BOX;
  localparam int W  = $clog2(N + 2);
  localparam int RW = $clog2(N);
  localparam int KW = $clog2(MAX_EMPTY + 1);
  localparam int LD = 1 << KW;
  localparam logic [W-1:0]  FAIL = W'(N + 1);
  localparam logic [W-1:0]  NV   = W'(N);
  localparam logic [RW-1:0] LAST = RW'(N - 1);
  localparam logic [KW-1:0] KMAX = KW'(MAX_EMPTY);

  typedef enum logic [1:0] {IDLE, LOAD, SOLVE, OUT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  grid_q [N][N];
  logic [W-1:0]  grid_d [N][N];
  logic [RW-1:0] lr_q [LD];
  logic [RW-1:0] lr_d [LD];
  logic [RW-1:0] lc_q [LD];
  logic [RW-1:0] lc_d [LD];
  logic [KW-1:0] e_q, e_d, k_q, k_d;
  logic [RW-1:0] r_q, r_d, c_q, c_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_q, out_d;
  logic          abort;

`ifdef SD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // A given clashes with an earlier given; cells not yet loaded are still zero.
  logic dup;
  always_comb begin
    dup = 1'b0;
    for (int rr = 0; rr < N; rr++) begin
      for (int cc = 0; cc < N; cc++) begin
        if ((rr == int'(r_q) || cc == int'(c_q) ||
             ((rr / BOX) == (int'(r_q) / BOX) && (cc / BOX) == (int'(c_q) / BOX))) &&
            bus.in != '0 && grid_q[rr][cc] == bus.in)
          dup = 1'b1;
      end
    end
  end

  // Next candidate for blank k: smallest value above the current one absent from its units.
  logic [RW-1:0] kr, kc;
  logic [N:0]    used;
  logic [W-1:0]  cur, cand;
  logic          cand_ok;
  always_comb begin
    kr      = lr_q[k_q];
    kc      = lc_q[k_q];
    cur     = grid_q[kr][kc];
    used    = '0;
    cand    = '0;
    cand_ok = 1'b0;
    for (int rr = 0; rr < N; rr++) begin
      for (int cc = 0; cc < N; cc++) begin
        if ((rr == int'(kr) || cc == int'(kc) ||
             ((rr / BOX) == (int'(kr) / BOX) && (cc / BOX) == (int'(kc) / BOX))) &&
            !(rr == int'(kr) && cc == int'(kc)) && grid_q[rr][cc] <= NV)
          used[grid_q[rr][cc]] = 1'b1;
      end
    end
    for (int v = N; v >= 1; v--) begin
      if (W'(v) > cur && !used[v]) begin
        cand    = W'(v);
        cand_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grid_d      = grid_q;
    lr_d        = lr_q;
    lc_d        = lc_q;
    e_d         = e_q;
    k_d         = k_q;
    r_d         = r_q;
    c_d         = c_q;
    err_d       = err_q;
    out_d       = '0;
    out_valid_d = 1'b0;
    abort       = 1'b0;
`ifdef SD_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          grid_d       = '{default: '0};
          grid_d[0][0] = bus.in;
          err_d        = (bus.in > NV);
          e_d          = '0;
          if (bus.in == '0) begin
            lr_d[0] = '0;
            lc_d[0] = '0;
            e_d     = KW'(1);
          end
          r_d     = '0;
          c_d     = RW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!bus.in_valid) begin
          err_d   = 1'b1;
          k_d     = '0;
          state_d = OUT;
        end else begin
          grid_d[r_q][c_q] = bus.in;
          if (bus.in > NV || dup) err_d = 1'b1;
          if (bus.in == '0) begin
            if (e_q < KMAX) begin
              lr_d[e_q] = r_q;
              lc_d[e_q] = c_q;
              e_d       = e_q + KW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
          if (c_q == LAST) begin
            c_d = '0;
            r_d = r_q + RW'(1);
          end else begin
            c_d = c_q + RW'(1);
          end
          if (r_q == LAST && c_q == LAST) begin
            k_d     = '0;
            state_d = (err_d || e_d == '0) ? OUT : SOLVE;
`ifdef SD_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      SOLVE: begin
`ifdef SD_TIMEOUT_EN
        if (cnt_q != TMAX) cnt_d = cnt_q + CW'(1);
        abort = (cnt_q == TMAX);
`endif
        if (abort) begin
          err_d   = 1'b1;
          k_d     = '0;
          state_d = OUT;
        end else if (cand_ok) begin
          grid_d[kr][kc] = cand;
          if (k_q + KW'(1) == e_q) begin
            k_d     = '0;
            state_d = OUT;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          grid_d[kr][kc] = '0;
          if (k_q == '0) begin
            err_d   = 1'b1;
            state_d = OUT;
          end else begin
            k_d = k_q - KW'(1);
          end
        end
      end
      OUT: begin
        out_valid_d = 1'b1;
        if (err_q) begin
          out_d   = FAIL;
          state_d = IDLE;
        end else if (e_q == '0) begin
          state_d = IDLE;
        end else begin
          out_d = grid_q[lr_q[k_q]][lc_q[k_q]];
          k_d   = k_q + KW'(1);
          if (k_q + KW'(1) == e_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grid_q      <= '{default: '0};
      lr_q        <= '{default: '0};
      lc_q        <= '{default: '0};
      e_q         <= '0;
      k_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
`ifdef SD_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grid_q      <= grid_d;
      lr_q        <= lr_d;
      lc_q        <= lc_d;
      e_q         <= e_d;
      k_q         <= k_d;
      r_q         <= r_d;
      c_q         <= c_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
`ifdef SD_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
endmodule

// File: tb/tb_sd_solver_param.sv
// Bench for sd_solver_param: a 9x9 and a 4x4 instance, directed puzzles plus randomized
// relabelled/blanked grids checked against a depth-first reference solver.
module tb_sd_solver_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sd_solver_param_if #(.W(4)) if3 ();
  sd_solver_param_if #(.W(3)) if2 ();

  sd_solver_param #(.BOX(3), .MAX_EMPTY(16), .TIMEOUT(4096)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));
  sd_solver_param #(.BOX(2), .MAX_EMPTY(16), .TIMEOUT(4096)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];
  int cur[256];
  int mg[16][16];

  int sol3[81] = '{5,3,4,6,7,8,9,1,2, 6,7,2,1,9,5,3,4,8, 1,9,8,3,4,2,5,6,7,
                   8,5,9,7,6,1,4,2,3, 4,2,6,8,5,3,7,9,1, 7,1,3,9,2,4,8,5,6,
                   9,6,1,5,3,7,2,8,4, 2,8,7,4,1,9,6,3,5, 3,4,5,2,8,6,1,7,9};
  int sol2[16] = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};
  int blanks15[15] = '{0,4,10,14,20,26,30,33,40,47,52,58,66,71,80};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic get_ov(input int sel);
    if (sel != 0) return if2.out_valid;
    return if3.out_valid;
  endfunction

  function automatic logic [4:0] get_out(input int sel);
    if (sel != 0) return 5'(if2.out);
    return 5'(if3.out);
  endfunction

  task automatic set_in(input int sel, input logic v, input int val);
    if (sel != 0) begin if2.in_valid = v; if2.in = 3'(val); end
    else begin if3.in_valid = v; if3.in = 4'(val); end
  endtask

  // Value v may sit at (r,c) if no other cell of its row, column or box holds v.
  function automatic bit cell_ok(input int n, input int box, input int r, input int c, input int v);
    int r0 = (r / box) * box;
    int c0 = (c / box) * box;
    for (int i = 0; i < n; i++) begin
      if (i != c && mg[r][i] == v) return 1'b0;
      if (i != r && mg[i][c] == v) return 1'b0;
    end
    for (int rr = r0; rr < r0 + box; rr++)
      for (int cc = c0; cc < c0 + box; cc++)
        if (!(rr == r && cc == c) && mg[rr][cc] == v) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: validate givens, then depth-first search over blanks in reading order, ascending values.
  function automatic void model(input int box, input int max_e);
    int n = box * box;
    int fail = n + 1;
    int br[$];
    int bc[$];
    bit err = 1'b0;
    int k;
    exp_q.delete();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) mg[r][c] = 0;
    for (int i = 0; i < n * n; i++) begin
      int r = i / n;
      int c = i % n;
      int v = cur[i];
      if (v > n) err = 1'b1;
      else if (v != 0 && !cell_ok(n, box, r, c, v)) err = 1'b1;
      if (v == 0) begin
        if (br.size() >= max_e) err = 1'b1;
        else begin br.push_back(r); bc.push_back(c); end
      end
      mg[r][c] = v;
    end
    if (err) begin exp_q.push_back(5'(fail)); return; end
    if (br.size() == 0) begin exp_q.push_back(5'd0); return; end
    k = 0;
    while (k < br.size()) begin
      int found = 0;
      for (int v = mg[br[k]][bc[k]] + 1; v <= n; v++)
        if (found == 0 && cell_ok(n, box, br[k], bc[k], v)) found = v;
      mg[br[k]][bc[k]] = found;
      if (found != 0) k++;
      else if (k == 0) begin exp_q.push_back(5'(fail)); return; end
      else k--;
    end
    foreach (br[i]) exp_q.push_back(5'(mg[br[i]][bc[i]]));
  endfunction

  task automatic drive(input int sel, input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk); #1;
      set_in(sel, 1'b1, cur[i]);
    end
    @(posedge clk); #1;
    set_in(sel, 1'b0, 0);
  endtask

  task automatic collect(input int sel, input int lat);
    int waited = 0;
    int got = 0;
    int want = exp_q.size();
    do begin
      @(negedge clk);
      waited++;
    end while (!get_ov(sel) && waited < 20000);
    check("out_seen", 32'(get_ov(sel)), 1);
    if (!get_ov(sel)) begin exp_q.delete(); return; end
    if (lat != 0) check("latency", waited, lat);
    while (get_ov(sel) && got < 300) begin
      if (exp_q.size() > 0) check("out_val", get_out(sel), 32'(exp_q.pop_front()));
      got++;
      @(negedge clk);
    end
    check("out_count", got, want);
    check("out_idle", get_out(sel), 0);
    exp_q.delete();
  endtask

  task automatic load_sol3();
    for (int i = 0; i < 81; i++) cur[i] = sol3[i];
  endtask

  task automatic load_puzzle1();
    load_sol3();
    foreach (blanks15[i]) cur[blanks15[i]] = 0;
  endtask

  task automatic pulse_reset_and_check(input string tag);
    int seen = 0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_ov"}, 32'(if3.out_valid), 0);
    check({tag, "_out"}, 32'(if3.out), 0);
    repeat (40) begin
      @(negedge clk);
      if (if3.out_valid) seen++;
    end
    check({tag, "_quiet"}, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ov3", 32'(if3.out_valid), 0);
    check("rst_out3", 32'(if3.out), 0);
    check("rst_ov2", 32'(if2.out_valid), 0);
    check("rst_out2", 32'(if2.out), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 15-blank 9x9 puzzle
    load_puzzle1();
    model(3, 16);
    check("p1_len", exp_q.size(), 15);
    drive(0, 81);
    collect(0, 0);

    // duplicate 5 in row 0
    load_sol3();
    cur[1] = 5;
    exp_q.push_back(5'd10);
    drive(0, 81);
    collect(0, 2);

    // 4x4 with two blanks
    for (int i = 0; i < 16; i++) cur[i] = sol2[i];
    cur[14] = 0; cur[15] = 0;
    exp_q.push_back(5'd2); exp_q.push_back(5'd1);
    drive(1, 16);
    collect(1, 0);

    // 17 blanks exceeds the list
    load_sol3();
    for (int i = 0; i < 17; i++) cur[i] = 0;
    exp_q.push_back(5'd10);
    drive(0, 81);
    collect(0, 2);

    // fully given valid grid
    load_sol3();
    exp_q.push_back(5'd0);
    drive(0, 81);
    collect(0, 2);

    // consistent but unsolvable 9x9: row 0 forces 5 at (0,0), column 0 already has 5
    load_sol3();
    cur[0] = 0; cur[28] = 0; cur[27] = 5;
    exp_q.push_back(5'd10);
    drive(0, 81);
    collect(0, 0);

    // consistent but unsolvable 4x4
    for (int i = 0; i < 16; i++) cur[i] = 0;
    cur[1] = 2; cur[2] = 3; cur[8] = 1; cur[12] = 4;
    exp_q.push_back(5'd5);
    drive(1, 16);
    collect(1, 0);

    // value above N
    for (int i = 0; i < 16; i++) cur[i] = sol2[i];
    cur[5] = 6;
    exp_q.push_back(5'd5);
    drive(1, 16);
    collect(1, 2);

    // in_valid drops early
    load_sol3();
    exp_q.push_back(5'd10);
    drive(0, 40);
    collect(0, 0);

    // reset mid-SOLVE
    load_puzzle1();
    drive(0, 81);
    pulse_reset_and_check("rst_solve");

    // reset mid-OUT
    load_puzzle1();
    drive(0, 81);
    begin
      int w = 0;
      while (!if3.out_valid && w < 5000) begin @(negedge clk); w++; end
      check("rst_out_seen", 32'(if3.out_valid), 1);
    end
    pulse_reset_and_check("rst_out");

    // fresh puzzle after resets
    load_puzzle1();
    model(3, 16);
    drive(0, 81);
    collect(0, 0);

    // randomized 9x9: relabelled solution, random blanks, occasional corrupted cell
    for (int t = 0; t < 8; t++) begin
      int p[10];
      int nb;
      for (int i = 0; i < 10; i++) p[i] = i;
      for (int i = 9; i > 1; i--) begin
        int j;
        int tmp;
        j = int'($urandom_range(1, i));
        tmp = p[i]; p[i] = p[j]; p[j] = tmp;
      end
      for (int i = 0; i < 81; i++) cur[i] = p[sol3[i]];
      nb = int'($urandom_range(1, 15));
      repeat (nb) cur[$urandom_range(0, 80)] = 0;
      if ($urandom_range(0, 2) == 0) cur[$urandom_range(0, 80)] = int'($urandom_range(0, 10));
      model(3, 16);
      drive(0, 81);
      collect(0, 0);
    end

    // randomized 4x4
    for (int t = 0; t < 8; t++) begin
      int p[5];
      int nb;
      for (int i = 0; i < 5; i++) p[i] = i;
      for (int i = 4; i > 1; i--) begin
        int j;
        int tmp;
        j = int'($urandom_range(1, i));
        tmp = p[i]; p[i] = p[j]; p[j] = tmp;
      end
      for (int i = 0; i < 16; i++) cur[i] = p[sol2[i]];
      nb = int'($urandom_range(0, 16));
      repeat (nb) cur[$urandom_range(0, 15)] = 0;
      if ($urandom_range(0, 2) == 0) cur[$urandom_range(0, 15)] = int'($urandom_range(0, 7));
      model(2, 16);
      drive(1, 16);
      collect(1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d passed of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
